// File: rtl/chbuf_writer_if.sv
// Bus-write and character-buffer write signals of chbuf_writer.
// master drives register strobes and sees buffer writes; slave is the writer block.
interface chbuf_writer_if #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int CW = 14
);
  logic          do_write;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_data;
  logic          chbuf_w;
  logic [CW-1:0] chbuf_adr;
  logic [7:0]    chbuf_data;
  logic [15:0]   status;

  modport master (
    output do_write, w_adr, w_data,
    input  chbuf_w, chbuf_adr, chbuf_data, status
  );

  modport slave (
    input  do_write, w_adr, w_data,
    output chbuf_w, chbuf_adr, chbuf_data, status
  );
endinterface

// File: rtl/chbuf_writer.sv
// Queues bus register writes and turns them into character-buffer cell writes (single, auto-inc, clear).
// WRITE reaches chbuf_w two edges after its strobe; a full command FIFO drops strobes and sets sticky overflow.
module chbuf_writer #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int CW        = 14,
  parameter int DEPTH     = 8,
  parameter int CLEAR_LEN = 16384
) (
  input logic          clk,
  input logic          rst,
  chbuf_writer_if.slave bus
);
  localparam int PW   = (CW > 8) ? CW : 8;
  localparam int PTRW = $clog2(DEPTH);
  localparam int LW   = PTRW + 1;

  localparam logic [2:0]    OP_SET = 3'd0;
  localparam logic [2:0]    OP_WR  = 3'd2;
  localparam logic [2:0]    OP_WRI = 3'd3;
  localparam logic [2:0]    OP_CLR = 3'd4;
  localparam logic [CW-1:0] FILL_LAST = CW'(CLEAR_LEN - 1);

  typedef struct packed {
    logic [2:0]    op;
    logic [PW-1:0] dat;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, FILL} state_t;

  state_t          state;
  cmd_t            fifo_mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [LW-1:0]   level;
  cmd_t            cmd;
  logic [CW-1:0]   cur_adr;
  logic [CW-1:0]   fill_adr;
  logic [7:0]      fill_chr;
  logic            ovf;

  logic          chbuf_w_r;
  logic [CW-1:0] chbuf_adr_r;
  logic [7:0]    chbuf_data_r;
  logic [15:0]   status_r;

  logic          is_cmd;
  logic          is_ovf_clr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [LW-1:0] level_nxt;
  logic          ovf_nxt;
  logic          busy_nxt;

  // Only the data bits a command can consume are stored in the FIFO.
  logic unused_bits;
  assign unused_bits = ^bus.w_data;

  always_comb begin
    is_cmd     = bus.do_write && !rst &&
                 (bus.w_adr == AW'(0) || bus.w_adr == AW'(2) ||
                  bus.w_adr == AW'(3) || bus.w_adr == AW'(4));
    is_ovf_clr = bus.do_write && !rst && (bus.w_adr == AW'(5));
    full       = (level == LW'(DEPTH));
    pop        = (state == IDLE) && (level != '0);
    push       = is_cmd && (!full || pop);
    drop       = is_cmd && full && !pop;
    level_nxt  = level + LW'(push) - LW'(pop);
    ovf_nxt    = drop | (ovf & ~is_ovf_clr);
    // Status is registered, so busy is predicted from the state this edge will leave behind.
    busy_nxt   = pop ||
                 (state == EXEC && cmd.op == OP_CLR) ||
                 (state == FILL && fill_adr != FILL_LAST) ||
                 (level_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{op: bus.w_adr[2:0], dat: bus.w_data[PW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      cmd          <= '0;
      cur_adr      <= '0;
      fill_adr     <= '0;
      fill_chr     <= '0;
      ovf          <= 1'b0;
      chbuf_w_r    <= 1'b0;
      chbuf_adr_r  <= '0;
      chbuf_data_r <= '0;
      status_r     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level     <= level_nxt;
      ovf       <= ovf_nxt;
      status_r  <= {8'h00, 4'(level_nxt), 2'b00, ovf_nxt, busy_nxt};
      chbuf_w_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cmd   <= fifo_mem[rd_ptr];
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= IDLE;
          case (cmd.op)
            OP_SET: cur_adr <= cmd.dat[CW-1:0];
            OP_WR, OP_WRI: begin
              chbuf_w_r    <= 1'b1;
              chbuf_adr_r  <= cur_adr;
              chbuf_data_r <= cmd.dat[7:0];
              if (cmd.op == OP_WRI) cur_adr <= cur_adr + 1'b1;
            end
            OP_CLR: begin
              fill_chr <= cmd.dat[7:0];
              fill_adr <= '0;
              state    <= FILL;
            end
            default: ;
          endcase
        end
        FILL: begin
          chbuf_w_r    <= 1'b1;
          chbuf_adr_r  <= fill_adr;
          chbuf_data_r <= fill_chr;
          fill_adr     <= fill_adr + 1'b1;
          if (fill_adr == FILL_LAST) begin
            cur_adr <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.chbuf_w    = chbuf_w_r;
  assign bus.chbuf_adr  = chbuf_adr_r;
  assign bus.chbuf_data = chbuf_data_r;
  assign bus.status     = status_r;
endmodule

// File: tb/tb_chbuf_writer.sv
// Random and directed register strobes against a command-level reference model;
// expected buffer writes go through a queue that a negedge monitor drains.
module tb_chbuf_writer;
  localparam int DEPTH     = 8;
  localparam int CLEAR_LEN = 16;

  logic clk;
  logic rst;

  chbuf_writer_if #(.AW(8), .DW(16), .CW(14)) bus ();

  chbuf_writer #(
    .AW(8), .DW(16), .CW(14), .DEPTH(DEPTH), .CLEAR_LEN(CLEAR_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] dat;
  } mcmd_t;

  typedef struct packed {
    logic [13:0] adr;
    logic [7:0]  dat;
  } wr_t;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 0;

  // Reference model state: pending commands, the command in progress and its age in clocks.
  mcmd_t       mq[$];
  wr_t         exp_q[$];
  bit          act = 0;
  int          age = 0;
  mcmd_t       cc;
  logic [13:0] mcur = '0;
  bit          movf = 0;
  logic [15:0] mstat = '0;
  logic [13:0] last_adr = '0;
  logic [7:0]  last_dat = '0;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  function automatic void emit(input logic [13:0] a, input logic [7:0] d);
    exp_q.push_back('{adr: a, dat: d});
    last_adr = a;
    last_dat = d;
  endfunction

  always @(posedge clk) begin
    bit was_full;
    bit popped;
    if (rst) begin
      mq.delete();
      act = 0; age = 0; mcur = '0; movf = 0;
      last_adr = '0; last_dat = '0; mstat = '0;
    end else begin
      was_full = (mq.size() == DEPTH);
      popped   = 0;
      if (act) begin
        age++;
        case (cc.op)
          8'h00: begin mcur = cc.dat[13:0]; act = 0; end
          8'h02: begin emit(mcur, cc.dat[7:0]); act = 0; end
          8'h03: begin emit(mcur, cc.dat[7:0]); mcur = mcur + 14'd1; act = 0; end
          default: begin
            if (age >= 2) emit(14'(age - 2), cc.dat[7:0]);
            if (age == CLEAR_LEN + 1) begin mcur = '0; act = 0; end
          end
        endcase
      end else if (mq.size() > 0) begin
        cc = mq.pop_front();
        act = 1; age = 0; popped = 1;
      end
      if (bus.do_write) begin
        case (bus.w_adr)
          8'h00, 8'h02, 8'h03, 8'h04: begin
            if (!was_full || popped) mq.push_back('{op: bus.w_adr, dat: bus.w_data});
            else movf = 1;
          end
          8'h05: movf = 0;
          default: ;
        endcase
      end
      mstat = {8'h00, 4'(mq.size()), 2'b00, movf, (act || mq.size() > 0)};
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      chk("wr_pulse", {31'b0, bus.chbuf_w}, {31'b0, exp_q.size() != 0});
      if (bus.chbuf_w && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_adr", {18'b0, bus.chbuf_adr}, {18'b0, e.adr});
        chk("wr_dat", {24'b0, bus.chbuf_data}, {24'b0, e.dat});
      end else if (!bus.chbuf_w) begin
        chk("hold_adr", {18'b0, bus.chbuf_adr}, {18'b0, last_adr});
        chk("hold_dat", {24'b0, bus.chbuf_data}, {24'b0, last_dat});
      end
      chk("status", {16'b0, bus.status}, {16'b0, mstat});
    end
  end

  task automatic strobe(input logic [7:0] a, input logic [15:0] d);
    bus.do_write = 1'b1;
    bus.w_adr    = a;
    bus.w_data   = d;
    @(posedge clk); #1;
    bus.do_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while ((act || mq.size() > 0) && c < bound) begin
      idle(1);
      c++;
    end
    chk("drain_in_time", {31'b0, c < bound}, 32'd1);
    idle(2);
  endtask

  task automatic chk_status_at_neg(input string nm, input logic [15:0] v);
    @(negedge clk);
    chk(nm, {16'b0, bus.status}, {16'b0, v});
    @(posedge clk); #1;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    bus.do_write = 1'b0;
    bus.w_adr    = '0;
    bus.w_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    @(negedge clk);
    chk("rst_status", {16'b0, bus.status}, 32'h0);
    chk("rst_w", {31'b0, bus.chbuf_w}, 32'h0);
    chk("rst_adr", {18'b0, bus.chbuf_adr}, 32'h0);
    chk("rst_dat", {24'b0, bus.chbuf_data}, 32'h0);
    @(posedge clk); #1;

    // Address set, auto-increment, then a plain write to observe the advanced pointer.
    strobe(8'h00, 16'h0010);
    strobe(8'h03, 16'h0041);
    strobe(8'h03, 16'h0042);
    strobe(8'h02, 16'h0043);
    wait_idle(50);

    // Pointer wrap at the top of the address space.
    strobe(8'h00, 16'h3FFF);
    strobe(8'h03, 16'h0058);
    strobe(8'h02, 16'h0059);
    wait_idle(50);

    // Unmapped register addresses.
    strobe(8'h01, 16'h00AA);
    strobe(8'h06, 16'h00BB);
    strobe(8'hFF, 16'h00CC);
    idle(3);
    chk_status_at_neg("decode_status", 16'h0000);

    // Clear, then a write to show the pointer went back to zero.
    strobe(8'h04, 16'h002E);
    wait_idle(100);
    chk_status_at_neg("clear_done_status", 16'h0000);
    strobe(8'h02, 16'h0077);
    wait_idle(50);

    // Ten back-to-back writes behind a clear: eight fit, two overflow.
    strobe(8'h04, 16'h0020);
    for (int i = 0; i < 10; i++) strobe(8'h02, 16'(16'h0030 + i));
    @(negedge clk);
    chk("ovf_full_status", {16'b0, bus.status}, 32'h0083);
    @(posedge clk); #1;
    wait_idle(200);
    chk_status_at_neg("ovf_sticky", 16'h0002);
    strobe(8'h05, 16'h0000);
    chk_status_at_neg("ovf_cleared", 16'h0000);

    // Reset during the fifth fill cycle.
    strobe(8'h04, 16'h0055);
    idle(6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(20);
    chk_status_at_neg("midfill_rst_status", 16'h0000);

    // Random command mix.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 19);
      if (r < 3)
        strobe(8'h00, ($urandom_range(0, 1) == 1) ? 16'(14'h3FFC + $urandom_range(0, 3)) : 16'($urandom));
      else if (r < 8)  strobe(8'h02, 16'($urandom));
      else if (r < 15) strobe(8'h03, 16'($urandom));
      else if (r == 15) strobe(8'h04, 16'($urandom));
      else if (r == 16) strobe(8'h05, 16'($urandom));
      else if (r == 17) strobe(8'h01, 16'($urandom));
      else strobe(8'($urandom_range(6, 255)), 16'($urandom));
      idle($urandom_range(0, 3));
    end
    wait_idle(2000);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
